prbs_burst_ctrl: RTL and testbench
==================================

// Module: prbs_burst_ctrl
// PURPOSE
//  Sequences the PRBS LFSR generator (load, polynomial select, enable) to emit
//  bursts of N pseudo-random bits with start/busy/done handshake, downstream
//  backpressure and optional single-bit error injection. Sits between host
//  control/config pins and the LFSR datapath, which only shifts when gen_en=1.
// PARAMETERS
//  CNT_W        16      width of burst length, bit counter and inject index
//  SEED_W       31      width of generator seed (max LFSR length, PRBS31)
//  DEFAULT_SEED 31'd1   seed substituted when the supplied seed is all-zero
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst_n      in   1       synchronous reset, ACTIVE-HIGH (1 = reset)
//  start      in   1       begin burst; accepted only in IDLE
//  abort      in   1       terminate burst; effective in LOAD/RUN
//  poly_sel   in   2       0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31
//  seed       in   SEED_W  initial LFSR state
//  burst_len  in   CNT_W   bits to emit; 0 = continuous until abort
//  inj_en     in   1       enable single-bit error injection
//  inj_idx    in   CNT_W   bit index (0-based) to invert
//  out_ready  in   1       downstream ready; generator advances only when 1
//  gen_load   out  1       one-cycle LFSR load strobe
//  gen_seed   out  SEED_W  seed value, valid while gen_load=1, else 0
//  gen_poly   out  2       latched poly_sel, held while busy
//  gen_en     out  1       LFSR shift enable / output bit valid
//  gen_inv    out  1       invert current output bit (injection)
//  busy       out  1       1 in LOAD and RUN
//  done       out  1       one-cycle pulse on normal burst completion
//  bit_cnt    out  CNT_W   bits emitted in current/last burst
// BEHAVIOUR
//  Reset (rst_n=1, any state, overrides all inputs): state IDLE; every output
//   0; bit_cnt 0; config latches 0. Applies on the clock edge it is sampled.
//  States: IDLE, LOAD, RUN, DONE. All outputs registered or decoded from state.
//  IDLE: start=1 -> latch poly_sel, seed, burst_len, inj_en, inj_idx; clear
//   bit_cnt; go LOAD. Config inputs are ignored at all other times.
//  LOAD (1 cycle): gen_load=1, busy=1. gen_seed = latched seed, except if the
//   low L bits are zero (L=7/15/23/31 per poly) -> gen_seed = DEFAULT_SEED.
//   Next RUN.
//  RUN: busy=1; gen_en = out_ready (combinational pass-through, same cycle).
//   Each cycle with gen_en=1: bit_cnt += 1. gen_inv = gen_en & inj_en &
//   (bit_cnt == inj_idx), evaluated on pre-increment bit_cnt.
//   burst_len!=0: gen_en=1 with bit_cnt==burst_len-1 -> DONE next cycle.
//   burst_len==0: never completes; bit_cnt wraps 2^CNT_W-1 -> 0 silently.
//  DONE (1 cycle): done=1, busy=0, gen_en=0; next IDLE.
//  abort=1 in LOAD or RUN -> IDLE next cycle, no done; gen_en still follows
//   out_ready in that cycle. Abort beats completion in the same cycle.
//  start while LOAD/RUN/DONE ignored (no queueing).
//  bit_cnt holds its final value in DONE/IDLE until the next accepted start.
//  gen_poly holds the latched value until the next accepted start or reset.
//  Latency: start sampled at edge T -> gen_load in cycle T+1 -> first gen_en
//   possible T+2 -> done in cycle after last gen_en. With out_ready=1 and
//   burst_len=N: done at T+N+2, start-to-idle N+3 cycles.
// TESTING
//  1 start, poly=3, seed=0, len=4, ready=1 -> gen_load@T+1 gen_seed=1,
//    gen_en T+2..T+5, done@T+6 only, bit_cnt=4, busy T+1..T+5.
//  2 poly=0, seed=31'h80 (low 7 bits 0) -> gen_seed=1; seed=31'h5 -> 5.
//  3 len=3, out_ready 1,0,0,1,1 -> gen_en mirrors ready, exactly 3 gen_en
//    pulses, bit_cnt 0,1,1,1,2,3, done the cycle after 3rd gen_en.
//  4 inj_en=1, inj_idx=2, len=5, ready=1 -> gen_inv=1 only with 3rd gen_en.
//  5 len=0 CNT_W=16, 65537 ready cycles -> bit_cnt wraps to 1, no done;
//    abort -> busy=0 next cycle, done never pulses; start while busy ignored.
//  6 rst_n=1 mid-RUN with start=1 -> all outputs 0 next cycle, state IDLE;
//    abort coincident with last bit of len=2 -> no done.

Source files
------------

// File: rtl/prbs_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_burst_ctrl_if
//  Description : Host / LFSR-datapath bundle for the PRBS burst controller.
//                Carries the host command and configuration pins together
//                with the generator control outputs.
//                  start, abort, poly_sel, seed, burst_len, inj_en, inj_idx,
//                  out_ready                    : host/downstream -> ctrl
//                  gen_load, gen_seed, gen_poly, gen_en, gen_inv,
//                  busy, done, bit_cnt          : ctrl -> host/LFSR
//                Modport master is the host side, slave is the controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface prbs_burst_ctrl_if #(
    parameter int CNT_W  = 16,
    parameter int SEED_W = 31
);
    logic              start;
    logic              abort;
    logic [1:0]        poly_sel;
    logic [SEED_W-1:0] seed;
    logic [CNT_W-1:0]  burst_len;
    logic              inj_en;
    logic [CNT_W-1:0]  inj_idx;
    logic              out_ready;

    logic              gen_load;
    logic [SEED_W-1:0] gen_seed;
    logic [1:0]        gen_poly;
    logic              gen_en;
    logic              gen_inv;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_cnt;

    modport master (
        output start, abort, poly_sel, seed, burst_len, inj_en, inj_idx,
               out_ready,
        input  gen_load, gen_seed, gen_poly, gen_en, gen_inv, busy, done,
               bit_cnt
    );

    modport slave (
        input  start, abort, poly_sel, seed, burst_len, inj_en, inj_idx,
               out_ready,
        output gen_load, gen_seed, gen_poly, gen_en, gen_inv, busy, done,
               bit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/prbs_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_burst_ctrl
//  Description : Sequences a PRBS LFSR generator to emit bursts of
//                burst_len pseudo-random bits (0 = continuous) with
//                start/busy/done handshake, downstream backpressure and
//                optional single-bit error injection.
//  Ports       : clk    - clock, posedge
//                rst_n  - synchronous reset, active HIGH despite the name
//                bus    - prbs_burst_ctrl_if.slave (host config/handshake in,
//                         generator control and status out)
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_burst_ctrl #(
    parameter int                 CNT_W        = 16,
    parameter int                 SEED_W       = 31,
    parameter logic [SEED_W-1:0]  DEFAULT_SEED = SEED_W'(1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    prbs_burst_ctrl_if.slave      bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // Configuration captured on an accepted start
    logic [1:0]        r_poly;
    logic [SEED_W-1:0] r_seed;
    logic [CNT_W-1:0]  r_len;
    logic              r_inj_en;
    logic [CNT_W-1:0]  r_inj_idx;
    logic [CNT_W-1:0]  r_bit_cnt;

    logic              w_start_acc;
    logic              w_gen_en;
    logic              w_last_bit;
    logic [SEED_W-1:0] w_len_mask;
    logic [SEED_W-1:0] w_load_seed;

    assign w_start_acc = (r_state == S_IDLE) && bus.start;

    // Output bit is valid only when downstream can take it
    assign w_gen_en    = (r_state == S_RUN) && bus.out_ready;

    // Final bit of a finite burst is being emitted this cycle
    assign w_last_bit  = w_gen_en && (r_len != '0) &&
                         (r_bit_cnt == r_len - CNT_W'(1));

    // Only the low L bits form the LFSR state for the selected polynomial;
    // an all-zero state there would lock the LFSR up, so substitute a seed.
    always_comb begin
        w_len_mask = '0;
        case (r_poly)
            2'd0:    w_len_mask = SEED_W'(64'h0000_007F);
            2'd1:    w_len_mask = SEED_W'(64'h0000_7FFF);
            2'd2:    w_len_mask = SEED_W'(64'h007F_FFFF);
            default: w_len_mask = SEED_W'(64'h7FFF_FFFF);
        endcase
        w_load_seed = ((r_seed & w_len_mask) == '0) ? DEFAULT_SEED : r_seed;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = bus.abort ? S_IDLE : S_RUN;
            S_RUN: begin
                // Abort takes priority over completion
                if (bus.abort)       w_state_nxt = S_IDLE;
                else if (w_last_bit) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= S_IDLE;
            r_poly    <= '0;
            r_seed    <= '0;
            r_len     <= '0;
            r_inj_en  <= 1'b0;
            r_inj_idx <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_poly    <= bus.poly_sel;
                r_seed    <= bus.seed;
                r_len     <= bus.burst_len;
                r_inj_en  <= bus.inj_en;
                r_inj_idx <= bus.inj_idx;
                r_bit_cnt <= '0;
            end else if (w_gen_en) begin
                // Wraps silently in continuous mode
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.gen_load = (r_state == S_LOAD);
    assign bus.gen_seed = (r_state == S_LOAD) ? w_load_seed : '0;
    assign bus.gen_poly = r_poly;
    assign bus.gen_en   = w_gen_en;
    // Compared against the pre-increment count: index 0 is the first bit
    assign bus.gen_inv  = w_gen_en && r_inj_en && (r_bit_cnt == r_inj_idx);
    assign bus.busy     = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.bit_cnt  = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs_burst_ctrl
//  Description : Self-checking bench for prbs_burst_ctrl. Inputs are driven
//                2 time units after each rising edge, outputs are sampled
//                1 unit later, mid-cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prbs_burst_ctrl;

    localparam int CNT_W  = 16;
    localparam int SEED_W = 31;

    logic clk = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prbs_burst_ctrl_if #(.CNT_W(CNT_W), .SEED_W(SEED_W)) bus ();

    prbs_burst_ctrl #(
        .CNT_W        (CNT_W),
        .SEED_W       (SEED_W),
        .DEFAULT_SEED (31'd1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reference seed rule: LFSR length is 7/15/23/31 for poly 0..3
    function automatic logic [63:0] exp_seed(input int poly, input logic [63:0] seed);
        int len;
        logic [63:0] low;
        len = 7 + 8 * poly;
        low = seed & ((64'd1 << len) - 64'd1);
        return (low == 0) ? 64'd1 : seed;
    endfunction

    task automatic idle_outputs_zero(input string tag);
        check({tag, "_load"}, bus.gen_load, 0);
        check({tag, "_seed"}, bus.gen_seed, 0);
        check({tag, "_poly"}, bus.gen_poly, 0);
        check({tag, "_en"},   bus.gen_en,   0);
        check({tag, "_inv"},  bus.gen_inv,  0);
        check({tag, "_busy"}, bus.busy,     0);
        check({tag, "_done"}, bus.done,     0);
        check({tag, "_cnt"},  bus.bit_cnt,  0);
    endtask

    // One complete burst from an IDLE window back to an IDLE window.
    // ready for RUN cycle i is pat[i] for i<pat_len, otherwise random
    // (mostly 1) when rnd is set, else 1.
    task automatic burst(input int poly, input logic [30:0] seed, input int len,
                         input bit inj, input int idx, input logic [31:0] pat,
                         input int pat_len, input bit rnd);
        int k;
        int i;
        int bound;
        bit r;
        bus.start     = 1'b1;
        bus.poly_sel  = 2'(poly);
        bus.seed      = seed;
        bus.burst_len = 16'(len);
        bus.inj_en    = inj;
        bus.inj_idx   = 16'(idx);
        bus.out_ready = 1'b1;
        cyc();
        // LOAD cycle; config pins now scrambled and must be ignored
        bus.start = 1'b0;
        if (rnd) begin
            bus.poly_sel  = 2'($urandom);
            bus.seed      = 31'($urandom);
            bus.burst_len = 16'($urandom);
            bus.inj_en    = 1'($urandom);
            bus.inj_idx   = 16'($urandom);
        end
        #1;
        check("load_strobe", bus.gen_load, 1);
        check("load_seed",   bus.gen_seed, exp_seed(poly, 64'(seed)));
        check("load_busy",   bus.busy,     1);
        check("load_en",     bus.gen_en,   0);
        check("load_poly",   bus.gen_poly, 64'(poly));
        k = 0;
        i = 0;
        bound = len * 20 + 50;
        while (k < len && i < bound) begin
            cyc();
            if (i < pat_len)  r = pat[i];
            else if (rnd)     r = ($urandom_range(0, 3) != 0);
            else              r = 1'b1;
            bus.out_ready = r;
            bus.start     = rnd ? 1'($urandom) : 1'b0;
            #1;
            check("run_en",   bus.gen_en,  64'(r));
            check("run_inv",  bus.gen_inv, 64'(r && inj && (k == idx)));
            check("run_cnt",  bus.bit_cnt, 64'(k));
            check("run_busy", bus.busy,    1);
            check("run_done", bus.done,    0);
            check("run_load", bus.gen_load | (bus.gen_seed != 0), 0);
            check("run_poly", bus.gen_poly, 64'(poly));
            if (r) k++;
            i++;
        end
        check("burst_bits_before_timeout", 64'(k), 64'(len));
        cyc();
        bus.out_ready = 1'($urandom);
        bus.start     = rnd ? 1'b1 : 1'b0;
        #1;
        check("done_pulse", bus.done,    1);
        check("done_busy",  bus.busy,    0);
        check("done_en",    bus.gen_en,  0);
        check("done_cnt",   bus.bit_cnt, 64'(len));
        cyc();
        bus.start = 1'b0;
        #1;
        check("after_done",  bus.done,     0);
        check("after_busy",  bus.busy,     0);
        check("after_load",  bus.gen_load, 0);
        check("after_cnt",   bus.bit_cnt,  64'(len));
        check("after_poly",  bus.gen_poly, 64'(poly));
    endtask

    initial begin
        bit saw_done;
        bit saw_gap;

        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.poly_sel  = 2'd3;
        bus.seed      = 31'h1234;
        bus.burst_len = 16'd7;
        bus.inj_en    = 1'b1;
        bus.inj_idx   = 16'd0;
        bus.out_ready = 1'b1;

        // Reset state
        cyc();
        bus.start = 1'b1;
        cyc();
        #1;
        idle_outputs_zero("reset");
        bus.start = 1'b0;
        rst_n     = 1'b0;
        cyc();

        // Basic burst, PRBS31 with zero seed
        burst(3, 31'h0, 4, 1'b0, 0, 32'h0, 0, 1'b0);
        // PRBS7 seed substitution and pass-through
        burst(0, 31'h80, 1, 1'b0, 0, 32'h0, 0, 1'b0);
        burst(0, 31'h5,  1, 1'b0, 0, 32'h0, 0, 1'b0);
        burst(1, 31'h8000, 2, 1'b0, 0, 32'h0, 0, 1'b0);
        // Backpressure pattern 1,0,0,1,1
        burst(2, 31'h33, 3, 1'b0, 0, 32'b11001, 5, 1'b0);
        // Injection on the third bit
        burst(1, 31'h77, 5, 1'b1, 2, 32'h0, 0, 1'b0);

        // Continuous mode: wrap, start ignored while busy, abort
        bus.start = 1'b1; bus.poly_sel = 2'd1; bus.seed = 31'h5;
        bus.burst_len = 16'd0; bus.inj_en = 1'b0; bus.out_ready = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        saw_done = 1'b0;
        saw_gap  = 1'b0;
        for (int n = 0; n < 65537; n++) begin
            bus.out_ready = 1'b1;
            bus.start     = (n == 100);
            bus.poly_sel  = 2'd2;
            #1;
            if (bus.done)    saw_done = 1'b1;
            if (!bus.gen_en) saw_gap  = 1'b1;
            cyc();
        end
        bus.abort = 1'b1;
        #1;
        check("cont_wrap_cnt", bus.bit_cnt, 1);
        check("cont_no_done",  64'(saw_done), 0);
        check("cont_no_gap",   64'(saw_gap), 0);
        check("cont_poly",     bus.gen_poly, 1);
        check("cont_abort_en", bus.gen_en, 1);
        cyc();
        bus.abort = 1'b0;
        #1;
        check("abort_busy", bus.busy,    0);
        check("abort_done", bus.done,    0);
        check("abort_cnt",  bus.bit_cnt, 2);
        cyc();
        #1;
        check("abort_done2", bus.done, 0);

        // Abort during LOAD
        bus.start = 1'b1; bus.burst_len = 16'd5; bus.poly_sel = 2'd0;
        bus.seed = 31'h9;
        cyc();
        bus.start = 1'b0; bus.abort = 1'b1;
        #1;
        check("ldabort_load", bus.gen_load, 1);
        check("ldabort_seed", bus.gen_seed, 9);
        cyc();
        bus.abort = 1'b0;
        #1;
        check("ldabort_busy", bus.busy,   0);
        check("ldabort_en",   bus.gen_en, 0);
        check("ldabort_done", bus.done,   0);
        cyc();

        // Abort coincident with last bit of len=2
        bus.start = 1'b1; bus.burst_len = 16'd2;
        cyc();
        bus.start = 1'b0;
        cyc();
        #1;
        check("lastabort_en1", bus.gen_en, 1);
        cyc();
        bus.abort = 1'b1;
        #1;
        check("lastabort_en2", bus.gen_en, 1);
        cyc();
        bus.abort = 1'b0;
        #1;
        check("lastabort_done", bus.done, 0);
        check("lastabort_busy", bus.busy, 0);
        check("lastabort_cnt",  bus.bit_cnt, 2);
        cyc();
        #1;
        check("lastabort_done2", bus.done, 0);

        // Reset mid-RUN with start asserted
        bus.start = 1'b1; bus.burst_len = 16'd10; bus.poly_sel = 2'd2;
        bus.seed = 31'h9;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        cyc();
        rst_n = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
        cyc();
        rst_n = 1'b0; bus.start = 1'b0;
        #1;
        idle_outputs_zero("midrst");
        cyc();

        // Randomised bursts against the reference rules
        for (int b = 0; b < 25; b++) begin
            int poly;
            int len;
            logic [30:0] sd;
            poly = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 20));
            sd   = 31'($urandom);
            if ($urandom_range(0, 2) == 0) sd = sd & ~31'((64'd1 << (7 + 8 * poly)) - 1);
            burst(poly, sd, len, 1'($urandom), int'($urandom_range(0, 24)),
                  32'h0, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
